fire_control: RTL and testbench
===============================

Name: fire_control

Overview:
- Trigger sequencer that sits directly upstream of the weapons block.
- Turns a raw pilot trigger into rate-limited, single-cycle `fire` strobes, with optional fixed-length bursts.
- Gates firing on attack mode (one-hot 4'b0010) and on available ammo.
- Feeds `fire` to the ammo saturation counter and reads that counter's live level back as `ammo_level`.

Parameters:
- AW, 9: width of the ammo, rate and shot-count datapaths.
- CDW, 4: width of the cooldown counter.
- BURST, 3: shots per burst when `burst_en` is set; must be ≥ 1.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- trigger, input, 1: pilot trigger level.
- mode_selector, input, 4: one-hot mode; 4'b0010 = attack.
- burst_en, input, 1: 1 = burst of BURST shots per press; 0 = single shot.
- cooldown, input, CDW: idle cycles inserted after each shot.
- ammo_level, input, AW: current ammo count from the downstream counter.
- fire_rate, input, AW: ammo consumed per shot.
- fire, output, 1: one-cycle fire strobe to the weapons block.
- busy, output, 1: sequence in progress.
- error, output, 1: illegal fire request; held high until trigger is released.
- reload_req, output, 1: ammo is below one shot's worth.
- shots_fired, output, AW: saturating count of strobes issued.

Behaviour:
- Clocking and reset
  - Single clock, `clk`. Reset is synchronous and active-high on `rst`.
  - When `rst` is sampled high: next state is IDLE; trigger_q, burst_left, cd_cnt, shots_fired and reload_req clear to 0. `fire`, `busy` and `error` are therefore 0 in the next cycle.
  - Reset mid-burst abandons the burst with no further strobe.
- Trigger edge and fire condition
  - `trigger` is registered into trigger_q every cycle. Rise = trigger & ~trigger_q.
  - ok = (mode_selector == 4'b0010) & (fire_rate != 0) & (ammo_level >= fire_rate). Comparison is unsigned at AW bits.
- State machine: IDLE, FIRE, COOL, LOCKOUT
  - IDLE:
    - On rise & ok: go to FIRE and load burst_left = burst_en ? BURST-1 : 0.
    - On rise & ~ok: go to LOCKOUT.
    - Otherwise stay in IDLE.
  - FIRE:
    - Lasts exactly one cycle; then go to COOL.
    - On exit, load cd_cnt = cooldown and increment shots_fired, saturating at all-ones.
  - COOL:
    - If cd_cnt != 0: decrement and stay. COOL therefore lasts cooldown+1 cycles, including when cooldown = 0.
    - At cd_cnt == 0:
      - burst_left != 0 & ok: go to FIRE and decrement burst_left.
      - burst_left != 0 & ~ok: go to LOCKOUT (burst aborted for mode change or ammo shortage).
      - burst_left == 0: go to IDLE.
  - LOCKOUT: stay until trigger_q == 0, then go to IDLE.
- Output decode (all Moore, registered state, no combinational path from inputs)
  - fire = (state == FIRE).
  - busy = (state == FIRE) | (state == COOL).
  - error = (state == LOCKOUT).
- Timing
  - Latency from the edge that samples the rise to `fire` high is 1 cycle.
  - Shot period inside a burst is cooldown+2 cycles.
  - The ok check at COOL exit sees `ammo_level` already decremented by the downstream counter, because COOL is at least 1 cycle long.
- Trigger handling
  - Releasing the trigger mid-burst does not stop the burst.
  - Holding the trigger after a burst or single shot never re-fires; a new rise is required.
  - A rise in FIRE, COOL or LOCKOUT is ignored.
- reload_req: registered each cycle as (ammo_level < fire_rate). It does not depend on state.
- cooldown is sampled only at FIRE exit; changing it mid-COOL has no effect on the current count.

Decomposition:
- Shared package weapons_pkg holds:
  - state encoding localparams: IDLE=2'd0, FIRE=2'd1, COOL=2'd2, LOCKOUT=2'd3;
  - ATTACK_MODE = 4'b0010;
  - default AW = 9.
- One sub-module, cooldown_timer, parameterised by CDW:
  - inputs: load, load value, enable;
  - output: zero flag;
  - replaces the inline cd_cnt logic.
- FSM, edge detect, burst counter and shot counter stay in fire_control.

Test Plan:
- Single shot. Setup: rst for 2 cycles, then ammo_level=500, fire_rate=3, mode=0010, burst_en=0, cooldown=2. Stimulus: trigger rises → fire high for exactly 1 cycle, 1 cycle after sampling; busy high for 4 cycles; shots_fired=1; holding trigger 20 more cycles gives no second strobe.
- Burst. Setup: burst_en=1, BURST=3, cooldown=1, ammo model decrementing by fire_rate per strobe. Stimulus: trigger pulse of 1 cycle → 3 fire strobes spaced 3 cycles apart; then IDLE; shots_fired=3; model ammo 500 → 491.
- Wrong mode. Setup: mode_selector=0001. Stimulus: trigger rises → no fire; error high from the next cycle until 1 cycle after trigger_q falls; busy stays 0.
- Ammo starvation mid-burst. Setup: ammo_level=5, fire_rate=3, burst_en=1. Stimulus: trigger rises → first strobe; model drops to 2 and reload_req rises; COOL exit goes to LOCKOUT with error=1; shots_fired=1.
- Reset mid-burst. Setup: burst_en=1, cooldown=4. Stimulus: assert rst in the 2nd COOL cycle → next cycle fire, busy, error, shots_fired and reload_req are all 0; no further strobes.
- fire_rate=0 and saturation. fire_rate=0 with trigger rise → LOCKOUT, no fire. Forcing shots_fired to 511 via repeated presses → stays at 511.

Source files
------------

// File: rtl/weapons_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : weapons_pkg
//  Description : Shared types and constants for the weapons trigger path:
//                sequencer state encoding, attack-mode code, default widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package weapons_pkg;

    // Sequencer states; the encoding is fixed so waveform decoders and
    // downstream monitors can rely on it.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FIRE    = 2'd1,
        COOL    = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    // One-hot mode code that enables firing.
    localparam logic [3:0] ATTACK_MODE = 4'b0010;

    // Default width of the ammo / rate / shot-count datapaths.
    localparam int DEFAULT_AW = 9;

endpackage : weapons_pkg
`default_nettype wire

// File: rtl/cooldown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : cooldown_timer
//  Description : Loadable down-counter that spaces consecutive shots.
//                Loads on 'load', counts down while 'en' is high and holds
//                at zero; 'zero' flags an expired count.
//  Revision    : 1.0 - initial release
// ============================================================================
module cooldown_timer #(
    parameter int CDW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic [CDW-1:0] load_val,
    input  logic           en,
    output logic           zero
);

    logic [CDW-1:0] r_cnt;

    // Load takes priority over counting so the value captured at shot exit
    // is never disturbed by a stale enable in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CDW'(1);
        end
    end

    assign zero = (r_cnt == '0);

endmodule : cooldown_timer
`default_nettype wire

// File: rtl/fire_control.sv
`default_nettype none
// ============================================================================
//  Module      : fire_control
//  Description : Trigger sequencer. Converts the pilot trigger level into
//                rate-limited single-cycle fire strobes (single shot or
//                fixed-length burst), gated on attack mode and ammo.
//  Revision    : 1.0 - initial release
// ============================================================================
module fire_control
    import weapons_pkg::*;
#(
    parameter int AW    = DEFAULT_AW,
    parameter int CDW   = 4,
    parameter int BURST = 3            // shots per burst, must be >= 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           trigger,
    input  logic [3:0]     mode_selector,
    input  logic           burst_en,
    input  logic [CDW-1:0] cooldown,
    input  logic [AW-1:0]  ammo_level,
    input  logic [AW-1:0]  fire_rate,
    output logic           fire,
    output logic           busy,
    output logic           error,
    output logic           reload_req,
    output logic [AW-1:0]  shots_fired
);

    // Remaining shots after the first one of a burst.
    localparam logic [AW-1:0] c_burst_load = AW'(BURST - 1);

    state_t        r_state;
    logic          r_trigger_q;
    logic [AW-1:0] r_burst_left;
    logic [AW-1:0] r_shots_fired;
    logic          r_reload_req;

    logic w_rise;
    logic w_ok;
    logic w_cd_zero;
    logic w_cd_load;
    logic w_cd_en;

    // A shot is legal only in attack mode with a nonzero rate and at least
    // one shot's worth of ammo. Unsigned compare at AW bits.
    assign w_rise = trigger & ~r_trigger_q;
    assign w_ok   = (mode_selector == ATTACK_MODE) &&
                    (fire_rate != '0) &&
                    (ammo_level >= fire_rate);

    // The cooldown value is captured only when leaving FIRE, so edits to
    // 'cooldown' during COOL do not affect the running count.
    assign w_cd_load = (r_state == FIRE);
    assign w_cd_en   = (r_state == COOL);

    cooldown_timer #(
        .CDW (CDW)
    ) u_cooldown_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_cd_load),
        .load_val (cooldown),
        .en       (w_cd_en),
        .zero     (w_cd_zero)
    );

    // Trigger history for edge detection and ammo-shortage flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_trigger_q  <= 1'b0;
            r_reload_req <= 1'b0;
        end else begin
            r_trigger_q  <= trigger;
            r_reload_req <= (ammo_level < fire_rate);
        end
    end

    // Sequencer: state, burst bookkeeping and saturating shot counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_burst_left  <= '0;
            r_shots_fired <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        if (w_ok) begin
                            r_state      <= FIRE;
                            r_burst_left <= burst_en ? c_burst_load : '0;
                        end else begin
                            r_state <= LOCKOUT;
                        end
                    end
                end
                FIRE: begin
                    r_state <= COOL;
                    if (r_shots_fired != '1) begin
                        r_shots_fired <= r_shots_fired + AW'(1);
                    end
                end
                COOL: begin
                    // ok is re-evaluated here against the already-updated
                    // ammo level, so a burst stops cleanly on shortage.
                    if (w_cd_zero) begin
                        if (r_burst_left != '0) begin
                            if (w_ok) begin
                                r_state      <= FIRE;
                                r_burst_left <= r_burst_left - AW'(1);
                            end else begin
                                r_state <= LOCKOUT;
                            end
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                LOCKOUT: begin
                    if (!r_trigger_q) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Moore decode of the registered state; no input reaches an output
    // combinationally.
    assign fire        = (r_state == FIRE);
    assign busy        = (r_state == FIRE) || (r_state == COOL);
    assign error       = (r_state == LOCKOUT);
    assign reload_req  = r_reload_req;
    assign shots_fired = r_shots_fired;

endmodule : fire_control
`default_nettype wire

// File: tb/tb_fire_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fire_control
//  Description : Directed self-checking bench for fire_control with a small
//                downstream ammo-counter model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fire_control;

    localparam int AW    = 9;
    localparam int CDW   = 4;
    localparam int BURST = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           trigger = 1'b0;
    logic [3:0]     mode_selector = 4'b0010;
    logic           burst_en = 1'b0;
    logic [CDW-1:0] cooldown = '0;
    logic [AW-1:0]  ammo_level = '0;
    logic [AW-1:0]  fire_rate = '0;
    logic           fire;
    logic           busy;
    logic           error;
    logic           reload_req;
    logic [AW-1:0]  shots_fired;

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  model_on = 1'b0;

    always #5 clk = ~clk;

    fire_control #(
        .AW    (AW),
        .CDW   (CDW),
        .BURST (BURST)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .trigger       (trigger),
        .mode_selector (mode_selector),
        .burst_en      (burst_en),
        .cooldown      (cooldown),
        .ammo_level    (ammo_level),
        .fire_rate     (fire_rate),
        .fire          (fire),
        .busy          (busy),
        .error         (error),
        .reload_req    (reload_req),
        .shots_fired   (shots_fired)
    );

    // Advance one clock; sample 1 time unit after the edge. The downstream
    // ammo counter decrements on the edge that ends a fire cycle.
    task automatic tick();
        logic f;
        f = fire;
        @(posedge clk);
        #1;
        if (model_on && f) begin
            ammo_level = (ammo_level >= fire_rate) ? ammo_level - fire_rate : '0;
        end
    endtask

    task automatic do_reset();
        trigger = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        ammo_level = 9'd0;
        fire_rate  = 9'd0;
        do_reset();
        n_checks++;
        if ({fire, busy, error, reload_req} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000", {fire, busy, error, reload_req});
        end
        n_checks++;
        if (shots_fired !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_shots: got %0d expected 0", shots_fired);
        end
    endtask

    task automatic test_single_shot();
        int first_fire = -1;
        int fire_cnt = 0;
        int busy_cnt = 0;
        mode_selector = 4'b0010; burst_en = 1'b0; cooldown = 4'd2;
        ammo_level = 9'd500; fire_rate = 9'd3; model_on = 1'b1;
        do_reset();
        trigger = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            tick();
            if (fire) begin
                fire_cnt++;
                if (first_fire < 0) first_fire = i;
            end
            if (busy) busy_cnt++;
        end
        trigger = 1'b0;
        n_checks++;
        if (first_fire !== 1) begin
            n_fail++;
            $display("FAIL single_latency: got %0d expected 1", first_fire);
        end
        n_checks++;
        if (fire_cnt !== 1) begin
            n_fail++;
            $display("FAIL single_count: got %0d strobes expected 1", fire_cnt);
        end
        n_checks++;
        if (busy_cnt !== 4) begin
            n_fail++;
            $display("FAIL single_busy: got %0d cycles expected 4", busy_cnt);
        end
        n_checks++;
        if (shots_fired !== 9'd1) begin
            n_fail++;
            $display("FAIL single_shots: got %0d expected 1", shots_fired);
        end
        tick();
    endtask

    task automatic test_burst();
        logic [15:0] fire_mask = '0;
        mode_selector = 4'b0010; burst_en = 1'b1; cooldown = 4'd1;
        ammo_level = 9'd500; fire_rate = 9'd3; model_on = 1'b1;
        do_reset();
        trigger = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 1) trigger = 1'b0;
            if (fire) fire_mask[i] = 1'b1;
        end
        n_checks++;
        if (fire_mask !== 16'h0092) begin
            n_fail++;
            $display("FAIL burst_pattern: got %h expected 0092", fire_mask);
        end
        n_checks++;
        if (shots_fired !== 9'd3) begin
            n_fail++;
            $display("FAIL burst_shots: got %0d expected 3", shots_fired);
        end
        n_checks++;
        if (ammo_level !== 9'd491) begin
            n_fail++;
            $display("FAIL burst_ammo: got %0d expected 491", ammo_level);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL burst_idle: busy %b expected 0", busy);
        end
    endtask

    task automatic test_wrong_mode();
        logic [15:0] err_mask = '0;
        logic [15:0] act_mask = '0;
        mode_selector = 4'b0001; burst_en = 1'b0; cooldown = 4'd0;
        ammo_level = 9'd500; fire_rate = 9'd3; model_on = 1'b0;
        do_reset();
        trigger = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (error) err_mask[i] = 1'b1;
            if (fire || busy) act_mask[i] = 1'b1;
            if (i == 5) trigger = 1'b0;
        end
        n_checks++;
        if (err_mask !== 16'h007E) begin
            n_fail++;
            $display("FAIL mode_error: got %h expected 007e", err_mask);
        end
        n_checks++;
        if (act_mask !== 16'h0000) begin
            n_fail++;
            $display("FAIL mode_nofire: got %h expected 0000", act_mask);
        end
        mode_selector = 4'b0010;
    endtask

    task automatic test_starvation();
        logic [15:0] fire_mask = '0;
        logic [15:0] err_mask = '0;
        logic        reload_at3 = 1'b0;
        mode_selector = 4'b0010; burst_en = 1'b1; cooldown = 4'd1;
        ammo_level = 9'd5; fire_rate = 9'd3; model_on = 1'b1;
        do_reset();
        trigger = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (fire) fire_mask[i] = 1'b1;
            if (error) err_mask[i] = 1'b1;
            if (i == 3) reload_at3 = reload_req;
        end
        n_checks++;
        if (fire_mask !== 16'h0002) begin
            n_fail++;
            $display("FAIL starve_fire: got %h expected 0002", fire_mask);
        end
        n_checks++;
        if (err_mask !== 16'h01F0) begin
            n_fail++;
            $display("FAIL starve_error: got %h expected 01f0", err_mask);
        end
        n_checks++;
        if (reload_at3 !== 1'b1) begin
            n_fail++;
            $display("FAIL starve_reload: got %b expected 1", reload_at3);
        end
        n_checks++;
        if (shots_fired !== 9'd1) begin
            n_fail++;
            $display("FAIL starve_shots: got %0d expected 1", shots_fired);
        end
        trigger = 1'b0;
        tick();
        tick();
        n_checks++;
        if (error !== 1'b0) begin
            n_fail++;
            $display("FAIL starve_release: error %b expected 0", error);
        end
    endtask

    task automatic test_reset_mid_burst();
        int late_fires = 0;
        mode_selector = 4'b0010; burst_en = 1'b1; cooldown = 4'd4;
        ammo_level = 9'd500; fire_rate = 9'd3; model_on = 1'b1;
        do_reset();
        trigger = 1'b1;
        tick();                // FIRE
        trigger = 1'b0;
        tick();                // COOL, 1st cycle
        tick();                // COOL, 2nd cycle
        n_checks++;
        if ({busy, shots_fired} !== {1'b1, 9'd1}) begin
            n_fail++;
            $display("FAIL midrst_pre: busy %b shots %0d expected busy 1 shots 1", busy, shots_fired);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({fire, busy, error, reload_req, shots_fired} !== 13'd0) begin
            n_fail++;
            $display("FAIL midrst_clear: flags %b shots %0d expected all 0",
                     {fire, busy, error, reload_req}, shots_fired);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (fire) late_fires++;
        end
        n_checks++;
        if (late_fires !== 0) begin
            n_fail++;
            $display("FAIL midrst_nofire: got %0d strobes expected 0", late_fires);
        end
    endtask

    task automatic test_zero_rate();
        mode_selector = 4'b0010; burst_en = 1'b0; cooldown = 4'd0;
        ammo_level = 9'd500; fire_rate = 9'd0; model_on = 1'b0;
        do_reset();
        trigger = 1'b1;
        tick();
        n_checks++;
        if ({fire, busy, error} !== 3'b001) begin
            n_fail++;
            $display("FAIL zero_rate: fire/busy/error %b expected 001", {fire, busy, error});
        end
        trigger = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({error, shots_fired} !== {1'b0, 9'd0}) begin
            n_fail++;
            $display("FAIL zero_rate_exit: error %b shots %0d expected 0 0", error, shots_fired);
        end
    endtask

    // Bursts of 3 with no cooldown: 170 presses reach 510, the next
    // press saturates at 511, and a further press keeps it there.
    task automatic press_burst(output int fires);
        fires = 0;
        trigger = 1'b1;
        tick();
        if (fire) fires++;
        trigger = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (fire) fires++;
        end
    endtask

    task automatic test_saturation();
        int f;
        int total = 0;
        mode_selector = 4'b0010; burst_en = 1'b1; cooldown = 4'd0;
        ammo_level = 9'd500; fire_rate = 9'd1; model_on = 1'b0;
        do_reset();
        for (int p = 0; p < 170; p++) begin
            press_burst(f);
            total += f;
        end
        n_checks++;
        if ({shots_fired, 32'(total)} !== {9'd510, 32'd510}) begin
            n_fail++;
            $display("FAIL sat_pre: shots %0d strobes %0d expected 510 510", shots_fired, total);
        end
        press_burst(f);
        n_checks++;
        if ({shots_fired, 32'(f)} !== {9'd511, 32'd3}) begin
            n_fail++;
            $display("FAIL sat_hit: shots %0d strobes %0d expected 511 3", shots_fired, f);
        end
        press_burst(f);
        n_checks++;
        if (shots_fired !== 9'd511) begin
            n_fail++;
            $display("FAIL sat_hold: got %0d expected 511", shots_fired);
        end
    endtask

    initial begin
        test_reset();
        test_single_shot();
        test_burst();
        test_wrong_mode();
        test_starvation();
        test_reset_mid_burst();
        test_zero_rate();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fire_control
`default_nettype wire
